superh16_decode_queue: RTL

Multi-wide, buffered decode stage between fetch and rename. It accepts up to FETCH_WIDTH raw 32-bit RISC-V instructions per cycle into a circular instruction queue. It decodes up to DECODE_WIDTH per cycle from the queue head into registered decoded_inst_t slots held for rename. It generalises the single-instruction combinational decoder with configurable width and depth, valid/ready backpressure, pipeline flush, illegal-instruction flagging, and rd suppression for formats that have no destination.

---
 rtl/superh16_decode_queue_pkg.sv | 124 ++++++++++++
 rtl/superh16_inst_fifo_mw.sv | 61 ++++++
 rtl/superh16_decode_queue.sv | 117 +++++++++++
 3 files changed

// File: rtl/superh16_decode_queue_pkg.sv
// Shared types and decode helpers for the buffered multi-wide decode stage.
// decode_instruction is the base decoder; is_legal_inst and fixup_decoded refine its result.
package superh16_decode_queue_pkg;

  localparam int unsigned FETCH_WIDTH_DEF  = 4;
  localparam int unsigned DECODE_WIDTH_DEF = 4;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_FP  = 7'b1010011;
  localparam logic [6:0] OPC_MADD   = 7'b1000011;
  localparam logic [6:0] OPC_MSUB   = 7'b1000111;
  localparam logic [6:0] OPC_NMSUB  = 7'b1001011;
  localparam logic [6:0] OPC_NMADD  = 7'b1001111;

  typedef enum logic [3:0] {
    UOP_NOP, UOP_ALU, UOP_MUL, UOP_DIV, UOP_LOAD, UOP_STORE, UOP_BRANCH, UOP_JAL,
    UOP_JALR, UOP_LUI, UOP_AUIPC, UOP_FADD, UOP_FMUL, UOP_FDIV, UOP_FSQRT, UOP_FMA
  } uop_e;

  typedef enum logic [2:0] {
    EXEC_NONE, EXEC_INT_ALU, EXEC_INT_MUL, EXEC_INT_DIV, EXEC_BRANCH, EXEC_LSU, EXEC_FP
  } exec_unit_e;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] inst;
    uop_e        opcode;
    exec_unit_e  exec_unit;
    logic [4:0]  src1_arch;
    logic [4:0]  src2_arch;
    logic [4:0]  src3_arch;
    logic [4:0]  dst_arch;
  } decoded_inst_t;

  function automatic decoded_inst_t decode_instruction(input logic [31:0] inst,
                                                       input logic [63:0] pc);
    decoded_inst_t d;
    d.pc        = pc;
    d.inst      = inst;
    d.opcode    = UOP_NOP;
    d.exec_unit = EXEC_NONE;
    d.src1_arch = inst[19:15];
    d.src2_arch = inst[24:20];
    d.src3_arch = '0;
    d.dst_arch  = inst[11:7];
    case (inst[6:0])
      OPC_LOAD:   begin d.opcode = UOP_LOAD;   d.exec_unit = EXEC_LSU;     d.src2_arch = '0; end
      // Store data travels on the third source port so src2 stays free for address math.
      OPC_STORE: begin
        d.opcode    = UOP_STORE;
        d.exec_unit = EXEC_LSU;
        d.src3_arch = inst[24:20];
        d.src2_arch = '0;
      end
      OPC_BRANCH: begin d.opcode = UOP_BRANCH; d.exec_unit = EXEC_BRANCH; end
      OPC_JAL: begin
        d.opcode = UOP_JAL; d.exec_unit = EXEC_BRANCH; d.src1_arch = '0; d.src2_arch = '0;
      end
      OPC_JALR:   begin d.opcode = UOP_JALR;   d.exec_unit = EXEC_BRANCH;  d.src2_arch = '0; end
      OPC_LUI:    begin d.opcode = UOP_LUI;    d.exec_unit = EXEC_INT_ALU; d.src2_arch = '0; end
      OPC_AUIPC: begin
        d.opcode = UOP_AUIPC; d.exec_unit = EXEC_INT_ALU; d.src1_arch = '0; d.src2_arch = '0;
      end
      OPC_OP_IMM: begin d.opcode = UOP_ALU;    d.exec_unit = EXEC_INT_ALU; d.src2_arch = '0; end
      OPC_OP: begin
        if (inst[31:25] == 7'h01) begin
          d.opcode    = inst[14] ? UOP_DIV : UOP_MUL;
          d.exec_unit = inst[14] ? EXEC_INT_DIV : EXEC_INT_MUL;
        end else begin
          d.opcode    = UOP_ALU;
          d.exec_unit = EXEC_INT_ALU;
        end
      end
      OPC_OP_FP: begin
        d.exec_unit = EXEC_FP;
        case (inst[31:27])
          5'b00000, 5'b00001: d.opcode = UOP_FADD;
          5'b00010:           d.opcode = UOP_FMUL;
          5'b00011:           d.opcode = UOP_FDIV;
          5'b01011:           begin d.opcode = UOP_FSQRT; d.src2_arch = '0; end
          default:            d.opcode = UOP_NOP;
        endcase
      end
      OPC_MADD, OPC_MSUB, OPC_NMSUB, OPC_NMADD: begin
        d.opcode = UOP_FMA; d.exec_unit = EXEC_FP; d.src3_arch = inst[31:27];
      end
      default: d.opcode = UOP_NOP;
    endcase
    return d;
  endfunction

  function automatic logic is_legal_inst(input logic [31:0] inst);
    logic       ok;
    logic [6:0] f7;
    f7 = inst[31:25];
    case (inst[6:0])
      OPC_LOAD, OPC_STORE, OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC, OPC_OP_IMM,
      OPC_MADD, OPC_MSUB, OPC_NMSUB, OPC_NMADD: ok = 1'b1;
      OPC_BRANCH: ok = (inst[14:13] != 2'b01);
      OPC_OP:     ok = (f7 == 7'h00) || (f7 == 7'h20) || (f7 == 7'h01);
      OPC_OP_FP:  ok = f7 inside {7'h00, 7'h01, 7'h04, 7'h05, 7'h08, 7'h09,
                                  7'h0C, 7'h0D, 7'h2C, 7'h2D};
      default:    ok = 1'b0;
    endcase
    return ok && (inst[1:0] == 2'b11);
  endfunction

  function automatic decoded_inst_t fixup_decoded(input decoded_inst_t d_in);
    decoded_inst_t d;
    d = d_in;
    if (d.opcode == UOP_STORE || d.opcode == UOP_BRANCH) d.dst_arch = '0;
    if (d.opcode == UOP_LUI) d.src1_arch = '0;
    return d;
  endfunction

endpackage

// File: rtl/superh16_inst_fifo_mw.sv
// Circular buffer taking up to WrWidth entries and releasing up to RdWidth entries per cycle.
module superh16_inst_fifo_mw #(
  parameter int unsigned WrWidth = 4,
  parameter int unsigned RdWidth = 4,
  parameter int unsigned Depth   = 16,
  parameter int unsigned Width   = 96
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          flush_i,
  input  logic [$clog2(Depth):0]        wr_num_i,
  input  logic [WrWidth-1:0][Width-1:0] wr_data_i,
  input  logic [$clog2(Depth):0]        rd_num_i,
  output logic [RdWidth-1:0][Width-1:0] rd_data_o,
  output logic [$clog2(Depth):0]        count_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CntW-1:0]  count_q, count_d;

  // Pointer truncation gives the modulo-Depth wrap for free.
  always_comb begin
    head_d  = head_q + PtrW'(rd_num_i);
    tail_d  = tail_q + PtrW'(wr_num_i);
    count_d = count_q + wr_num_i - rd_num_i;
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < WrWidth; i++) begin
      if (!flush_i && (CntW'(i) < wr_num_i)) mem_q[tail_q + PtrW'(i)] <= wr_data_i[i];
    end
  end

  always_comb begin
    for (int j = 0; j < RdWidth; j++) rd_data_o[j] = mem_q[head_q + PtrW'(j)];
  end

  assign count_o = count_q;

endmodule

// File: rtl/superh16_decode_queue.sv
// Buffered multi-wide decode stage: fetch bundles queue up, and up to DECODE_WIDTH are
// decoded from the head into registered slots that hold until rename takes them.
module superh16_decode_queue
  import superh16_decode_queue_pkg::*;
#(
  parameter int unsigned FETCH_WIDTH  = FETCH_WIDTH_DEF,
  parameter int unsigned DECODE_WIDTH = DECODE_WIDTH_DEF,
  parameter int unsigned DEPTH        = 16
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               flush,
  input  logic [FETCH_WIDTH-1:0]             fetch_valid,
  input  logic [FETCH_WIDTH-1:0][31:0]       fetch_inst,
  input  logic [FETCH_WIDTH-1:0][63:0]       fetch_pc,
  output logic                               fetch_ready,
  output logic [DECODE_WIDTH-1:0]            dec_valid,
  output decoded_inst_t [DECODE_WIDTH-1:0]   dec_inst,
  output logic [DECODE_WIDTH-1:0]            dec_illegal,
  input  logic                               rename_ready,
  output logic [$clog2(DEPTH):0]             occupancy
);

  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  logic [CntW-1:0]                    count, lead_num, wr_num, rd_num, avail;
  logic [FETCH_WIDTH-1:0][95:0]       wr_data;
  logic [DECODE_WIDTH-1:0][95:0]      rd_data;
  logic                               load;
  decoded_inst_t [DECODE_WIDTH-1:0]   slot_dec;
  logic [DECODE_WIDTH-1:0]            slot_legal;

  logic [DECODE_WIDTH-1:0]            dec_valid_q, dec_valid_d;
  logic [DECODE_WIDTH-1:0]            dec_illegal_q, dec_illegal_d;
  decoded_inst_t [DECODE_WIDTH-1:0]   dec_inst_q, dec_inst_d;

  // Only the leading run of valid lanes is taken, so a malformed mask cannot leave holes.
  always_comb begin
    logic run;
    run      = 1'b1;
    lead_num = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      run = run & fetch_valid[i];
      if (run) lead_num = CntW'(i + 1);
      wr_data[i] = {fetch_inst[i], fetch_pc[i]};
    end
  end

  assign fetch_ready = (count <= CntW'(DEPTH - FETCH_WIDTH));
  assign wr_num      = (fetch_ready && !flush) ? lead_num : '0;
  assign load        = rename_ready || (dec_valid_q == '0);
  assign avail       = (count < CntW'(DECODE_WIDTH)) ? count : CntW'(DECODE_WIDTH);
  assign rd_num      = (load && !flush) ? avail : '0;

  superh16_inst_fifo_mw #(
    .WrWidth (FETCH_WIDTH),
    .RdWidth (DECODE_WIDTH),
    .Depth   (DEPTH),
    .Width   (96)
  ) u_fifo (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .flush_i   (flush),
    .wr_num_i  (wr_num),
    .wr_data_i (wr_data),
    .rd_num_i  (rd_num),
    .rd_data_o (rd_data),
    .count_o   (count)
  );

  for (genvar g = 0; g < DECODE_WIDTH; g++) begin : g_slot
    assign slot_legal[g] = is_legal_inst(rd_data[g][95:64]);
    assign slot_dec[g]   = fixup_decoded(decode_instruction(rd_data[g][95:64], rd_data[g][63:0]));
  end

  always_comb begin
    dec_valid_d   = dec_valid_q;
    dec_illegal_d = dec_illegal_q;
    dec_inst_d    = dec_inst_q;
    if (flush) begin
      dec_valid_d   = '0;
      dec_illegal_d = '0;
    end else if (load) begin
      for (int j = 0; j < DECODE_WIDTH; j++) begin
        dec_inst_d[j] = slot_dec[j];
        // Illegal slots keep pc/inst so the exception can still be raised downstream.
        if (!slot_legal[j]) begin
          dec_inst_d[j].opcode    = UOP_NOP;
          dec_inst_d[j].exec_unit = EXEC_NONE;
        end
        dec_valid_d[j]   = CntW'(j) < rd_num;
        dec_illegal_d[j] = dec_valid_d[j] & ~slot_legal[j];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dec_valid_q   <= '0;
      dec_illegal_q <= '0;
      dec_inst_q    <= '0;
    end else begin
      dec_valid_q   <= dec_valid_d;
      dec_illegal_q <= dec_illegal_d;
      dec_inst_q    <= dec_inst_d;
    end
  end

  assign dec_valid   = dec_valid_q;
  assign dec_illegal = dec_illegal_q;
  assign dec_inst    = dec_inst_q;
  assign occupancy   = count;

  fetch_valid_thermo_a: assert property (@(posedge clk) disable iff (!rst_n)
    (fetch_valid & (fetch_valid + FETCH_WIDTH'(1))) == '0);

endmodule
